ex_issue_ctrl: RTL and testbench

//  Issue controller between decode and the EX stage. It owns the ID/EX register for ALU control fields
//  (funct3, funct7, aluCtrlOp, itype) and destination info, and sequences the ALU.

---
 rtl/ex_issue_ctrl_pkg.sv | 26 ++
 rtl/ex_issue_ctrl_hazard_detect.sv | 30 +++
 rtl/ex_issue_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ex_issue_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_issue_ctrl_pkg.sv
// rtl/ex_issue_ctrl_pkg.sv - shared encodings and types for the EX issue controller
//   ALU_OP_*  : aluCtrlOp encodings carried through ID/EX
//   state_t   : issue FSM states (run / load-use bubble / wrong-path flush)
//   ex_ctrl_t : ALU control fields held in the ID/EX register
package ex_issue_ctrl_pkg;

  localparam logic [1:0] ALU_OP_LDST   = 2'b00;
  localparam logic [1:0] ALU_OP_ALU    = 2'b01;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [1:0] alu_ctrl_op;
    logic       itype;
    logic       mem_read;
    logic       reg_write;
  } ex_ctrl_t;

endpackage

// File: rtl/ex_issue_ctrl_hazard_detect.sv
// rtl/ex_issue_ctrl_hazard_detect.sv - combinational load-use hazard compare
//   ex_valid, ex_mem_read, ex_reg_write, ex_rd : instruction currently in EX
//   id_valid, id_use_rs1/2, id_rs1/2          : instruction in decode
//   hz                                         : decode reads a register a live load in EX will write
module hazard_detect
  import ex_issue_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  id_valid,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  output logic                  hz
);

  logic load_in_ex;
  logic rs_match;

  // x0 is hardwired, so a load targeting it can never create a dependency.
  assign load_in_ex = ex_valid & ex_mem_read & ex_reg_write & (ex_rd != '0);
  assign rs_match   = (id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd));
  assign hz         = load_in_ex & id_valid & rs_match;

endmodule

// File: rtl/ex_issue_ctrl.sv
// rtl/ex_issue_ctrl.sv - decode-to-EX issue controller with load-use bubble and branch flush
//   clk, rst                    : clock, asynchronous active-high reset
//   id_*                        : decode instruction, id_ready accepts it
//   ex_*                        : registered ID/EX copy, ex_valid marks a live instruction
//   ex_branch_taken, mem_busy   : EX branch resolution, downstream memory stall
//   if_flush, id_flush          : one-cycle kill pulses on a taken branch
//   stall_cnt                   : saturating count of cycles with id_valid & !id_ready
module ex_issue_ctrl
  import ex_issue_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [2:0]            id_funct3,
  input  logic [6:0]            id_funct7,
  input  logic [1:0]            id_alu_ctrl_op,
  input  logic                  id_itype,
  input  logic                  id_mem_read,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  output logic                  ex_valid,
  output logic [2:0]            ex_funct3,
  output logic [6:0]            ex_funct7,
  output logic [1:0]            ex_alu_ctrl_op,
  output logic                  ex_itype,
  output logic                  ex_mem_read,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  if_flush,
  output logic                  id_flush,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int              FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  state_t                state;
  state_t                state_nxt;
  logic [FC_W-1:0]       flush_cnt;
  ex_ctrl_t              ex_q;
  logic [REG_ADDR_W-1:0] ex_rd_q;
  logic                  ex_valid_q;
  logic [CNT_W-1:0]      stall_q;
  logic                  hz;
  logic                  tk;
  logic                  issue;  // load ID/EX from decode
  logic                  drain;  // empty EX, keep the old fields

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard (
    .ex_valid    (ex_valid_q),
    .ex_mem_read (ex_q.mem_read),
    .ex_reg_write(ex_q.reg_write),
    .ex_rd       (ex_rd_q),
    .id_valid    (id_valid),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .hz          (hz)
  );

  // A taken branch is only acted on when the stage is not frozen.
  assign tk = ex_valid_q & ex_branch_taken & ~mem_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!mem_busy) begin
      case (state)
        ST_RUN: begin
          if (tk) begin
            state_nxt = ST_FLUSH;
          end else if (hz) begin
            state_nxt = ST_STALL;
          end
        end
        ST_STALL: state_nxt = ST_RUN;
        ST_FLUSH: begin
          if (flush_cnt == '0) begin
            state_nxt = ST_RUN;
          end
        end
        default:  state_nxt = ST_RUN;
      endcase
    end
  end

  always_comb begin
    id_ready = 1'b0;
    if_flush = 1'b0;
    id_flush = 1'b0;
    issue    = 1'b0;
    drain    = 1'b0;
    if (!mem_busy) begin
      case (state)
        ST_RUN: begin
          if (tk) begin
            // Wrong-path decode instruction is consumed and discarded.
            if_flush = 1'b1;
            id_flush = 1'b1;
            id_ready = 1'b1;
            drain    = 1'b1;
          end else if (hz) begin
            drain = 1'b1;
          end else begin
            id_ready = 1'b1;
            issue    = 1'b1;
          end
        end
        // The bubble already cleared ex_valid, so no hazard or branch can be pending.
        ST_STALL: begin
          id_ready = 1'b1;
          issue    = 1'b1;
        end
        ST_FLUSH: begin
          id_ready = 1'b1;
          drain    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      ex_rd_q    <= '0;
    end else if (issue) begin
      ex_valid_q       <= id_valid;
      ex_q.funct3      <= id_funct3;
      ex_q.funct7      <= id_funct7;
      ex_q.alu_ctrl_op <= id_alu_ctrl_op;
      ex_q.itype       <= id_itype;
      ex_q.mem_read    <= id_mem_read;
      ex_q.reg_write   <= id_reg_write;
      ex_rd_q          <= id_rd;
    end else if (drain) begin
      ex_valid_q <= 1'b0;
    end
  end

  // Loaded on branch entry and counted down inside FLUSH; frozen by mem_busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (!mem_busy) begin
      if (state == ST_RUN && tk) begin
        flush_cnt <= FC_LOAD;
      end else if (state == ST_FLUSH && flush_cnt != '0) begin
        flush_cnt <= flush_cnt - FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (id_valid && !id_ready && stall_q != {CNT_W{1'b1}}) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_funct3      = ex_q.funct3;
  assign ex_funct7      = ex_q.funct7;
  assign ex_alu_ctrl_op = ex_q.alu_ctrl_op;
  assign ex_itype       = ex_q.itype;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_rd          = ex_rd_q;
  assign ex_reg_write   = ex_q.reg_write;
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// tb/tb_ex_issue_ctrl.sv - scoreboard bench for ex_issue_ctrl
module tb_ex_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [1:0]  id_alu_ctrl_op;
  logic        id_itype, id_mem_read, id_reg_write;
  logic        ex_valid;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [1:0]  ex_alu_ctrl_op;
  logic        ex_itype, ex_mem_read, ex_reg_write;
  logic [4:0]  ex_rd;
  logic        ex_branch_taken, mem_busy;
  logic        if_flush, id_flush;
  logic [15:0] stall_cnt;

  logic        sat_id_ready, sat_ex_valid, sat_if_flush, sat_id_flush;
  logic [2:0]  sat_ex_funct3;
  logic [6:0]  sat_ex_funct7;
  logic [1:0]  sat_ex_alu_ctrl_op;
  logic        sat_ex_itype, sat_ex_mem_read, sat_ex_reg_write;
  logic [4:0]  sat_ex_rd;
  logic [3:0]  sat_cnt;

  localparam logic [1:0] OP_LDST = 2'b00, OP_ALU = 2'b01, OP_BR = 2'b10;

  int          errors = 0;
  int          checks = 0;
  logic [19:0] sb_q[$];
  logic        held;
  logic [19:0] ex_pack;

  always #5 clk = ~clk;

  ex_issue_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_alu_ctrl_op(id_alu_ctrl_op),
    .id_itype(id_itype), .id_mem_read(id_mem_read), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .ex_valid(ex_valid), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_alu_ctrl_op(ex_alu_ctrl_op), .ex_itype(ex_itype), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .if_flush(if_flush), .id_flush(id_flush), .stall_cnt(stall_cnt)
  );

  // Small-counter instance held permanently stalled to reach saturation quickly.
  ex_issue_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(1'b1), .id_ready(sat_id_ready),
    .id_rs1(5'd0), .id_rs2(5'd0), .id_use_rs1(1'b0), .id_use_rs2(1'b0),
    .id_funct3(3'd0), .id_funct7(7'd0), .id_alu_ctrl_op(2'd0),
    .id_itype(1'b0), .id_mem_read(1'b0), .id_rd(5'd0), .id_reg_write(1'b0),
    .ex_valid(sat_ex_valid), .ex_funct3(sat_ex_funct3), .ex_funct7(sat_ex_funct7),
    .ex_alu_ctrl_op(sat_ex_alu_ctrl_op), .ex_itype(sat_ex_itype), .ex_mem_read(sat_ex_mem_read),
    .ex_rd(sat_ex_rd), .ex_reg_write(sat_ex_reg_write), .ex_branch_taken(1'b0),
    .mem_busy(1'b1), .if_flush(sat_if_flush), .id_flush(sat_id_flush), .stall_cnt(sat_cnt)
  );

  assign ex_pack = {ex_funct3, ex_funct7, ex_alu_ctrl_op, ex_itype, ex_mem_read, ex_rd, ex_reg_write};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] id_pack();
    return {id_funct3, id_funct7, id_alu_ctrl_op, id_itype, id_mem_read, id_rd, id_reg_write};
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic mr, input logic rw,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2);
    id_valid       = v;
    id_alu_ctrl_op = op;
    id_mem_read    = mr;
    id_reg_write   = rw;
    id_rd          = rd;
    id_rs1         = rs1;
    id_use_rs1     = u1;
    id_rs2         = rs2;
    id_use_rs2     = u2;
    id_funct3      = rd[2:0] ^ rs1[2:0];
    id_funct7      = {rs2, rs1[1:0]};
    id_itype       = ~u2;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic accept();
    sb_q.push_back(id_pack());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // An instruction is new in EX only if the edge that produced it was not frozen.
  always @(posedge clk) held <= mem_busy;

  always @(negedge clk) begin
    if (ex_valid === 1'b1 && held === 1'b0) begin
      if (sb_q.size() == 0) check("sb_unexpected_issue", 32'(ex_pack), 32'hdead);
      else check("sb_fields", 32'(ex_pack), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    idle();
    ex_branch_taken = 1'b0;
    mem_busy        = 1'b0;
    repeat (2) tick();
    check("rst_ex_valid", ex_valid, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_if_flush", if_flush, 0);
    check("rst_id_flush", id_flush, 0);
    check("rst_fields", 32'(ex_pack), 0);
    rst = 1'b0;

    // back-to-back ALU ops
    drive(1, OP_ALU, 0, 1, 5'd1, 5'd2, 1, 5'd3, 1); accept(); #1;
    check("t1_ready_a", id_ready, 1);
    tick(); check("t1_valid_a", ex_valid, 1);
    drive(1, OP_ALU, 0, 1, 5'd2, 5'd1, 1, 5'd4, 1); accept(); #1;
    check("t1_ready_b", id_ready, 1);
    tick(); check("t1_valid_b", ex_valid, 1);
    idle(); tick();
    check("t1_empty", ex_valid, 0);
    check("t1_stall_cnt", stall_cnt, 0);

    // load-use on rs1
    drive(1, OP_LDST, 1, 1, 5'd5, 5'd1, 1, 5'd0, 0); accept(); #1;
    check("t2_ld_ready", id_ready, 1);
    tick();
    drive(1, OP_ALU, 0, 1, 5'd6, 5'd5, 1, 5'd7, 1); #1;
    check("t2_hz_ready", id_ready, 0);
    check("t2_hz_flush", if_flush, 0);
    tick();
    check("t2_bubble", ex_valid, 0);
    check("t2_hold_rd", ex_rd, 5);
    accept(); #1;
    check("t2_stall_ready", id_ready, 1);
    tick();
    check("t2_issue", ex_valid, 1);
    check("t2_stall_cnt", stall_cnt, 1);
    idle(); tick();

    // both sources match: still one bubble
    drive(1, OP_LDST, 1, 1, 5'd9, 5'd2, 1, 5'd0, 0); accept(); tick();
    drive(1, OP_ALU, 0, 1, 5'd10, 5'd9, 1, 5'd9, 1); #1;
    check("dbl_hz_ready", id_ready, 0);
    tick(); check("dbl_bubble", ex_valid, 0);
    accept(); #1; check("dbl_stall_ready", id_ready, 1);
    tick(); check("dbl_issue", ex_valid, 1);
    check("dbl_stall_cnt", stall_cnt, 2);
    idle(); tick();

    // load to x0 never stalls
    drive(1, OP_LDST, 1, 1, 5'd0, 5'd3, 1, 5'd0, 0); accept(); tick();
    drive(1, OP_ALU, 0, 1, 5'd6, 5'd0, 1, 5'd1, 1); accept(); #1;
    check("t3_ready", id_ready, 1);
    tick(); check("t3_issue", ex_valid, 1);
    check("t3_stall_cnt", stall_cnt, 2);
    idle(); tick();

    // taken branch, two-cycle flush
    drive(1, OP_BR, 0, 0, 5'd0, 5'd1, 1, 5'd2, 1); accept(); tick();
    check("t4_br_valid", ex_valid, 1);
    ex_branch_taken = 1'b1;
    drive(1, OP_ALU, 0, 1, 5'd11, 5'd1, 1, 5'd2, 1); #1;
    check("t4_if_flush", if_flush, 1);
    check("t4_id_flush", id_flush, 1);
    check("t4_tk_ready", id_ready, 1);
    tick(); ex_branch_taken = 1'b0;
    check("t4_drop0", ex_valid, 0);
    drive(1, OP_ALU, 0, 1, 5'd12, 5'd1, 1, 5'd2, 1); #1;
    check("t4_flush_pulse_end", if_flush, 0);
    check("t4_fl_ready0", id_ready, 1);
    tick(); check("t4_drop1", ex_valid, 0);
    drive(1, OP_ALU, 0, 1, 5'd13, 5'd1, 1, 5'd2, 1); #1;
    check("t4_fl_ready1", id_ready, 1);
    tick(); check("t4_drop2", ex_valid, 0);
    drive(1, OP_ALU, 0, 1, 5'd14, 5'd3, 1, 5'd2, 1); accept(); #1;
    check("t4_run_ready", id_ready, 1);
    tick(); check("t4_issue", ex_valid, 1);
    check("t4_stall_cnt", stall_cnt, 2);
    idle(); tick();

    // memory stall over a load-use hazard
    drive(1, OP_LDST, 1, 1, 5'd3, 5'd4, 1, 5'd0, 0); accept(); tick();
    mem_busy = 1'b1;
    drive(1, OP_ALU, 0, 1, 5'd4, 5'd1, 1, 5'd3, 1); #1;
    check("t5_busy_ready", id_ready, 0);
    check("t5_busy_flush", id_flush, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_frozen_valid", ex_valid, 1);
      check("t5_frozen_rd", ex_rd, 3);
    end
    check("t5_cnt_busy", stall_cnt, 5);
    mem_busy = 1'b0; #1;
    check("t5_hz_ready", id_ready, 0);
    tick(); check("t5_bubble", ex_valid, 0);
    check("t5_stall_cnt", stall_cnt, 6);
    accept(); #1;
    tick(); check("t5_issue", ex_valid, 1);
    idle(); tick();

    // reset while in STALL
    drive(1, OP_LDST, 1, 1, 5'd7, 5'd1, 1, 5'd0, 0); accept(); tick();
    drive(1, OP_ALU, 0, 1, 5'd8, 5'd7, 1, 5'd0, 0); #1;
    check("t6_hz_ready", id_ready, 0);
    tick();
    rst = 1'b1; #1;
    check("t6_rst_valid", ex_valid, 0);
    check("t6_rst_cnt", stall_cnt, 0);
    check("t6_rst_flush", if_flush, 0);
    check("t6_rst_rd", ex_rd, 0);
    tick(); rst = 1'b0;
    accept(); #1;
    check("t6_run_ready", id_ready, 1);
    tick(); check("t6_issue", ex_valid, 1);
    idle(); tick();

    // saturation of the 4-bit instance, counting since reset release
    repeat (12) tick();
    check("sat_14", sat_cnt, 14);
    check("sat_ready", sat_id_ready, 0);
    tick(); check("sat_15", sat_cnt, 15);
    repeat (3) tick(); check("sat_hold", sat_cnt, 15);

    check("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
